// File: rtl/regfile_wr_arbiter.sv
// ============================================================================
// regfile_wr_arbiter
//
// Write-port arbiter for the 32x32 pipeline register file, which has a single
// write port. The writeback stage (primary) always wins the port. The
// multicycle mul/div result path (secondary) posts writes into a small
// circular FIFO that drains into write slots the primary leaves idle.
//
// A pending-register mask tells the hazard unit which registers still have a
// buffered write in flight. A primary write to a pending register squashes
// the older buffered writes to that register and raises a sticky error flag.
//
// Optional feature (compile-time macro RFARB_STARVE_EN):
//   When defined, a 4-bit starvation counter tracks how long a valid FIFO
//   head has been blocked by primary writes. stall_req is raised once the
//   counter reaches STARVE_LIMIT, so the pipeline can yield a slot.
//   When undefined, no counter is built and stall_req is tied low.
//
// Parameters:
//   DEPTH        secondary FIFO entries (power of two, 2..8)
//   STARVE_LIMIT blocked cycles before stall_req asserts (1..15)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   wb_we      in   primary write enable
//   wb_wa      in   primary write address [4:0]
//   wb_wd      in   primary write data [31:0]
//   mc_valid   in   secondary write offered
//   mc_ready   out  secondary write accepted when mc_valid && mc_ready
//   mc_wa      in   secondary write address [4:0]
//   mc_wd      in   secondary write data [31:0]
//   rf_we      out  register file write enable (combinational)
//   rf_wa      out  register file write address (combinational)
//   rf_wd      out  register file write data (combinational)
//   pend_mask  out  bit r set while a valid FIFO entry targets r (registered)
//   stall_req  out  starvation stall request (registered)
//   err        out  sticky: a primary write hit a pending register
// ============================================================================
module regfile_wr_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we,
    input  logic [4:0]  wb_wa,
    input  logic [31:0] wb_wd,
    input  logic        mc_valid,
    output logic        mc_ready,
    input  logic [4:0]  mc_wa,
    input  logic [31:0] mc_wd,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic [31:0] pend_mask,
    output logic        stall_req,
    output logic        err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Reject illegal configurations at elaboration time. DEPTH must be a
    // power of two so the pointers wrap naturally at their bit width.
    generate
        if ((DEPTH < 2) || (DEPTH > 8) || ((DEPTH & (DEPTH - 1)) != 0) ||
            (STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_params
            $error("regfile_wr_arbiter: DEPTH must be a power of two in 2..8 and STARVE_LIMIT in 1..15");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------------
    logic [4:0]       entry_wa [DEPTH];
    logic [31:0]      entry_wd [DEPTH];
    logic [DEPTH-1:0] entry_v;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic             fifo_nonempty;
    logic             primary_issue;
    logic             head_valid;
    logic             pop;
    logic             accept;
    logic             push;
    logic             pend_hit;

    logic [DEPTH-1:0] v_next;
    logic [4:0]       wa_next [DEPTH];
    logic [31:0]      mask_next;
    logic [PTR_W-1:0] head_next;
    logic [PTR_W-1:0] tail_next;
    logic [CNT_W-1:0] count_next;

    // Slot arbitration and handshake decisions for this cycle. A primary
    // issue needs a nonzero address; writes to $0 leave the slot free. The
    // head is popped whenever the primary does not take the slot, whether it
    // is written (valid head) or discarded (squashed head). Secondary writes
    // to $0 are accepted but never enqueued.
    always_comb begin
        fifo_nonempty = (count != '0);
        primary_issue = !rst && wb_we && (wb_wa != 5'd0);
        head_valid    = fifo_nonempty && entry_v[head];
        pop           = !rst && !primary_issue && fifo_nonempty;
        mc_ready      = !rst && (count < DEPTH_C);
        accept        = mc_valid && mc_ready;
        push          = accept && (mc_wa != 5'd0);
        pend_hit      = primary_issue && pend_mask[wb_wa];
    end

    // Register file port mux. Primary first, then a valid FIFO head. Reset
    // forces the port idle so no write leaks out while the block is cleared.
    always_comb begin
        rf_we = 1'b0;
        rf_wa = 5'd0;
        rf_wd = 32'd0;
        if (!rst) begin
            if (primary_issue) begin
                rf_we = 1'b1;
                rf_wa = wb_wa;
                rf_wd = wb_wd;
            end else if (head_valid) begin
                rf_we = 1'b1;
                rf_wa = entry_wa[head];
                rf_wd = entry_wd[head];
            end
        end
    end

    // Next-state valid bits. The order matters: a primary write first
    // invalidates every older entry with the same address, then the popped
    // head is retired, and finally a freshly accepted entry is marked valid.
    // That last step keeps a same-cycle secondary write to the primary's
    // register alive, since it is younger than the primary write.
    always_comb begin
        v_next = entry_v;
        for (int i = 0; i < DEPTH; i++) begin
            if (primary_issue && (entry_wa[i] == wb_wa)) begin
                v_next[i] = 1'b0;
            end
        end
        if (pop) begin
            v_next[head] = 1'b0;
        end
        if (push) begin
            v_next[tail] = 1'b1;
        end
    end

    // Pending mask built from the next-state contents, so the registered
    // mask always matches the entries that will be in the FIFO next cycle.
    always_comb begin
        mask_next = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            wa_next[i] = (push && (tail == PTR_W'(i))) ? mc_wa : entry_wa[i];
            if (v_next[i]) begin
                mask_next[wa_next[i]] = 1'b1;
            end
        end
    end

    // Pointer and occupancy updates. Squashed entries still count until
    // popped; a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        head_next = pop  ? head + PTR_W'(1) : head;
        tail_next = push ? tail + PTR_W'(1) : tail;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Control state register. Reset discards every buffered entry and clears
    // the sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            entry_v   <= '0;
            pend_mask <= 32'd0;
            err       <= 1'b0;
        end else begin
            head      <= head_next;
            tail      <= tail_next;
            count     <= count_next;
            entry_v   <= v_next;
            pend_mask <= mask_next;
            if (pend_hit) begin
                err <= 1'b1;
            end
        end
    end

    // Payload storage needs no reset: an entry is only read while its valid
    // bit is set, and push is already blocked during reset.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_wa[tail] <= mc_wa;
            entry_wd[tail] <= mc_wd;
        end
    end

`ifdef RFARB_STARVE_EN
    // ------------------------------------------------------------------------
    // Starvation detection
    // ------------------------------------------------------------------------
    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    logic [3:0] starve_cnt_next;
    logic       head_blocked;
    logic       stall_q;

    // Count cycles where a valid head lost the slot to the primary. Any pop
    // or an empty FIFO restarts the count; saturate so it never wraps and
    // drops stall_req while the head is still stuck.
    always_comb begin
        head_blocked    = primary_issue && head_valid;
        starve_cnt_next = starve_cnt;
        if (pop || !fifo_nonempty) begin
            starve_cnt_next = 4'd0;
        end else if (head_blocked && (starve_cnt != 4'hF)) begin
            starve_cnt_next = starve_cnt + 4'd1;
        end
    end

    // stall_req follows the next counter value, so it rises together with
    // the counter reaching the limit and falls the cycle after the pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
            stall_q    <= 1'b0;
        end else begin
            starve_cnt <= starve_cnt_next;
            stall_q    <= (starve_cnt_next >= LIMIT_C);
        end
    end

    assign stall_req = stall_q;
`else
    assign stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// ============================================================================
// tb_regfile_wr_arbiter
//
// Directed testbench for regfile_wr_arbiter (DEPTH=2, STARVE_LIMIT=4).
// Inputs change 1 time unit after a rising edge; combinational outputs are
// sampled 1 time unit after that, registered outputs right after the edge.
// Expected stall_req behaviour follows RFARB_STARVE_EN.
// ============================================================================
module tb_regfile_wr_arbiter;

`ifdef RFARB_STARVE_EN
    localparam logic STARVE_ON = 1'b1;
`else
    localparam logic STARVE_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_wa;
    logic [31:0] mc_wd;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [31:0] pend_mask;
    logic        stall_req;
    logic        err;

    int checks = 0;
    int errors = 0;

    regfile_wr_arbiter #(
        .DEPTH        (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_we     (wb_we),
        .wb_wa     (wb_wa),
        .wb_wd     (wb_wd),
        .mc_valid  (mc_valid),
        .mc_ready  (mc_ready),
        .mc_wa     (mc_wa),
        .mc_wd     (mc_wd),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .pend_mask (pend_mask),
        .stall_req (stall_req),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's worth of inputs, then let combinational outputs settle.
    task automatic applyStimulus(input logic r,
                                 input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic mv, input logic [4:0] ma, input logic [31:0] md);
        rst      = r;
        wb_we    = we;
        wb_wa    = wa;
        wb_wd    = wd;
        mc_valid = mv;
        mc_wa    = ma;
        mc_wd    = md;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkPort(input string tag, input logic we, input logic [4:0] wa,
                             input logic [31:0] wd);
        checkOutput({tag, ".rf_we"}, {31'd0, rf_we}, {31'd0, we});
        if (we) begin
            checkOutput({tag, ".rf_wa"}, {27'd0, rf_wa}, {27'd0, wa});
            checkOutput({tag, ".rf_wd"}, rf_wd, wd);
        end
    endtask

    initial begin
        $display("[TB] starting regfile_wr_arbiter directed test");
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();

        // Reset with both producers active.
        applyStimulus(1'b1, 1'b1, 5'd3, 32'h0000_0333, 1'b1, 5'd5, 32'h5555_5555);
        checkOutput("rst.rf_we", {31'd0, rf_we}, 32'd0);
        checkOutput("rst.mc_ready", {31'd0, mc_ready}, 32'd0);
        tick();
        checkOutput("rst.pend_mask", pend_mask, 32'd0);
        checkOutput("rst.err", {31'd0, err}, 32'd0);
        checkOutput("rst.stall_req", {31'd0, stall_req}, 32'd0);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("rel.mc_ready", {31'd0, mc_ready}, 32'd1);
        checkOutput("rel.rf_we", {31'd0, rf_we}, 32'd0);

        // Secondary write with primary idle: one cycle latency, no pass-through.
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        checkOutput("sec.accept_ready", {31'd0, mc_ready}, 32'd1);
        checkOutput("sec.no_passthru", {31'd0, rf_we}, 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("sec.pend", pend_mask, 32'h0000_0020);
        checkPort("sec.write", 1'b1, 5'd5, 32'hDEAD_BEEF);
        tick();
        checkOutput("sec.pend_clr", pend_mask, 32'd0);
        checkPort("sec.idle", 1'b0, 5'd0, 32'd0);

        // Fill under continuous primary writes to reg 1, then drain.
        applyStimulus(1'b0, 1'b1, 5'd1, 32'h1111_0001, 1'b1, 5'd3, 32'h0000_0033);
        checkPort("fill.prim0", 1'b1, 5'd1, 32'h1111_0001);
        checkOutput("fill.ready0", {31'd0, mc_ready}, 32'd1);
        tick();
        applyStimulus(1'b0, 1'b1, 5'd1, 32'h1111_0002, 1'b1, 5'd4, 32'h0000_0044);
        checkPort("fill.prim1", 1'b1, 5'd1, 32'h1111_0002);
        checkOutput("fill.ready1", {31'd0, mc_ready}, 32'd1);
        tick();
        applyStimulus(1'b0, 1'b1, 5'd1, 32'h1111_0003, 1'b1, 5'd6, 32'h0000_0066);
        checkOutput("fill.full_ready", {31'd0, mc_ready}, 32'd0);
        checkOutput("fill.pend", pend_mask, 32'h0000_0018);
        tick();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkPort("drain.reg3", 1'b1, 5'd3, 32'h0000_0033);
        checkOutput("drain.ready_full", {31'd0, mc_ready}, 32'd0);
        tick();
        checkPort("drain.reg4", 1'b1, 5'd4, 32'h0000_0044);
        checkOutput("drain.ready_back", {31'd0, mc_ready}, 32'd1);
        checkOutput("drain.pend4", pend_mask, 32'h0000_0010);
        tick();
        checkPort("drain.empty", 1'b0, 5'd0, 32'd0);
        checkOutput("drain.pend0", pend_mask, 32'd0);

        // Squash: buffered reg 7 overtaken by a primary write to reg 7.
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_0077);
        tick();
        applyStimulus(1'b0, 1'b1, 5'd7, 32'h0000_0011, 1'b0, 5'd0, 32'd0);
        checkPort("sq.prim", 1'b1, 5'd7, 32'h0000_0011);
        checkOutput("sq.pend_before", pend_mask, 32'h0000_0080);
        checkOutput("sq.err_before", {31'd0, err}, 32'd0);
        tick();
        // Idle slot: the squashed head is popped silently while reg 8 enters.
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h0000_0088);
        checkOutput("sq.pend_after", pend_mask, 32'd0);
        checkOutput("sq.err", {31'd0, err}, 32'd1);
        checkOutput("sq.silent_pop_we", {31'd0, rf_we}, 32'd0);
        tick();
        // Count must now be 1: one more entry fits before the FIFO is full.
        applyStimulus(1'b0, 1'b1, 5'd1, 32'h1111_0004, 1'b1, 5'd10, 32'h0000_00AA);
        checkOutput("sq.count_ready", {31'd0, mc_ready}, 32'd1);
        checkOutput("sq.pend8", pend_mask, 32'h0000_0100);
        tick();
        checkOutput("sq.full_ready", {31'd0, mc_ready}, 32'd0);
        checkOutput("sq.pend8_10", pend_mask, 32'h0000_0500);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkPort("sq.drain8", 1'b1, 5'd8, 32'h0000_0088);
        tick();
        checkPort("sq.drain10", 1'b1, 5'd10, 32'h0000_00AA);
        tick();
        checkPort("sq.drained", 1'b0, 5'd0, 32'd0);
        checkOutput("sq.err_sticky", {31'd0, err}, 32'd1);

        // $0 handling: primary write to $0 leaves the slot to the FIFO head.
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_0099);
        tick();
        applyStimulus(1'b0, 1'b1, 5'd0, 32'h0000_0BAD, 1'b0, 5'd0, 32'd0);
        checkPort("z.wb0_head", 1'b1, 5'd9, 32'h0000_0099);
        tick();
        checkOutput("z.pend_empty", pend_mask, 32'd0);
        // Secondary write to $0 is consumed without occupying a slot.
        applyStimulus(1'b0, 1'b1, 5'd1, 32'h1111_0005, 1'b1, 5'd0, 32'hDEAD_0000);
        checkOutput("z.mc0_ready", {31'd0, mc_ready}, 32'd1);
        tick();
        checkOutput("z.mc0_pend", pend_mask, 32'd0);
        applyStimulus(1'b0, 1'b1, 5'd1, 32'h1111_0006, 1'b1, 5'd12, 32'h0000_000C);
        tick();
        applyStimulus(1'b0, 1'b1, 5'd1, 32'h1111_0007, 1'b1, 5'd13, 32'h0000_000D);
        checkOutput("z.count_unchanged", {31'd0, mc_ready}, 32'd1);
        tick();
        checkOutput("z.full", {31'd0, mc_ready}, 32'd0);
        checkOutput("z.pend12_13", pend_mask, 32'h0000_3000);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkPort("z.drain12", 1'b1, 5'd12, 32'h0000_000C);
        tick();
        checkPort("z.drain13", 1'b1, 5'd13, 32'h0000_000D);
        tick();

        // Starvation: reg 2 buffered under constant primary writes.
        applyStimulus(1'b0, 1'b1, 5'd1, 32'h1111_0008, 1'b1, 5'd2, 32'h0000_0022);
        tick();
        applyStimulus(1'b0, 1'b1, 5'd1, 32'h1111_0009, 1'b0, 5'd0, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            checkOutput($sformatf("st.blocked%0d", i), {31'd0, stall_req},
                        {31'd0, (i >= 4) && STARVE_ON});
        end
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkPort("st.release", 1'b1, 5'd2, 32'h0000_0022);
        checkOutput("st.stall_hold", {31'd0, stall_req}, {31'd0, STARVE_ON});
        tick();
        checkOutput("st.stall_drop", {31'd0, stall_req}, 32'd0);
        checkPort("st.empty", 1'b0, 5'd0, 32'd0);

        // Mid-operation reset drops buffered entries and the sticky error.
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'h0000_0020);
        tick();
        checkOutput("mr.pend", pend_mask, 32'h0010_0000);
        applyStimulus(1'b1, 1'b1, 5'd6, 32'h0000_0006, 1'b0, 5'd0, 32'd0);
        checkOutput("mr.rf_we", {31'd0, rf_we}, 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("mr.pend_clr", pend_mask, 32'd0);
        checkOutput("mr.err_clr", {31'd0, err}, 32'd0);
        checkOutput("mr.lost_entry", {31'd0, rf_we}, 32'd0);
        checkOutput("mr.ready", {31'd0, mc_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Write-port arbiter for the 32x32 pipeline register file, which has one write port. The pipeline writeback stage has absolute priority. A secondary producer (multicycle mul/div result path) posts writes through a small FIFO that drains into idle write slots. The block exports a pending-register mask for the hazard unit, plus an optional starvation stall request.

## Interface
- DEPTH, 2: secondary FIFO entries; power of two, 2..8.
- STARVE_LIMIT, 4: consecutive blocked cycles of a valid FIFO head before stall_req asserts; 1..15.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- wb_we  in  1  primary write enable.
- wb_wa  in  5  primary write address.
- wb_wd  in  32  primary write data.
- mc_valid  in  1  secondary write offered.
- mc_ready  out  1  secondary write accepted when mc_valid && mc_ready.
- mc_wa  in  5  secondary write address.
- mc_wd  in  32  secondary write data.
- rf_we  out  1  register file WE; combinational.
- rf_wa  out  5  register file WA; combinational.
- rf_wd  out  32  register file WD; combinational.
- pend_mask  out  32  bit r set while any valid FIFO entry targets register r; registered.
- stall_req  out  1  starvation stall request to the pipeline; registered.
- err  out  1  sticky flag: a primary write hit a pending register.

## Operation
- FIFO is circular: head pointer, tail pointer, count (0..DEPTH), and a per-entry valid bit.
- Slot selection, combinational, each cycle:
  - If rst: rf_we=0.
  - Else if wb_we && wb_wa!=0: rf_*=wb_*. This is a primary issue.
  - Else if the head entry is valid: rf_we=1, rf_wa/rf_wd from head. Pop at the clock edge.
  - Else if count>0 and the head is invalid (squashed): rf_we=0. Pop the head silently.
  - Else rf_we=0.
- wb_we with wb_wa==0 is a no-op. The slot stays free for the FIFO.
- mc_ready = !rst && count<DEPTH. There is no pass-through from mc to rf. An accepted entry is written no earlier than the next cycle.
- An accepted secondary write with mc_wa==0 is consumed and discarded; it is not enqueued.
- Push and pop in the same cycle: count is unchanged, and both pointers advance modulo DEPTH.
- Primary write to a pending register (wb_we, wb_wa!=0, pend_mask[wb_wa]=1):
  - The primary write proceeds.
  - Every FIFO entry with that address is invalidated at the edge.
  - err is set and stays set until rst.
  - Invalidated entries still occupy count until popped.
- Same-cycle accept of mc_wa==R alongside a primary write to R: the new entry is enqueued valid. It is younger than the primary write.
- pend_mask is recomputed each cycle from the next-state valid entries.

## Timing
- Reset values:
  - count=0, all valid bits=0, head=tail=0.
  - pend_mask=0, stall_req=0, err=0.
  - starvation counter=0.
  - mc_ready=0 and rf_we=0 while rst=1.
- Primary latency: 0 cycles. The register file is written at the rising edge ending the cycle in which wb_we is asserted.
- Secondary latency: minimum 1 cycle. Accept at edge N; the earliest register-file write is at edge N+1, when the FIFO was empty and the primary is idle.
- Full: count==DEPTH drops mc_ready in the same cycle. It rises again the cycle after a pop.
- Reset asserted mid-operation: all buffered entries are lost. No rf write occurs in that cycle.

## Configuration
- RFARB_STARVE_EN defined:
  - A 4-bit counter increments each cycle the FIFO head is valid but blocked by a primary issue.
  - The counter clears on any pop or when the FIFO is empty.
  - stall_req is registered high when counter >= STARVE_LIMIT and stays high until the head is popped. It drops the cycle after the pop.
- RFARB_STARVE_EN undefined: no counter is built, and stall_req is tied to 0.

## Test plan
- Reset check: assert rst with mc_valid=1 and wb_we=1. Require rf_we=0, mc_ready=0, pend_mask=0, err=0. After release, mc_ready=1 on the next cycle.
- Secondary write, primary idle: accept mc_wa=5, mc_wd=0xDEADBEEF.
  - pend_mask[5]=1 after the edge.
  - Next cycle: rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF.
  - pend_mask=0 afterwards.
- Fill and drain with DEPTH=2 and continuous primary writes to reg 1:
  - Push regs 3 and 4; mc_ready=0 on the third offer.
  - Drop wb_we; regs 3 then 4 are written on consecutive cycles.
  - mc_ready returns after the first pop.
- Squash: FIFO holds reg 7. A primary write to reg 7 with 0x11 occurs.
  - Register file receives 0x11.
  - pend_mask[7]=0 and err=1.
  - Next idle cycle: rf_we=0 and count decrements.
- $0 handling:
  - wb_wa=0 with wb_we=1 and a FIFO head for reg 9: reg 9 is written in that cycle.
  - mc_wa=0 accepted: count is unchanged.
- Starvation (RFARB_STARVE_EN, STARVE_LIMIT=4): FIFO holds reg 2 under constant primary writes.
  - stall_req=1 after 4 blocked cycles.
  - Drop wb_we: reg 2 is written, and stall_req=0 the following cycle.
  - Without the macro, stall_req stays 0 throughout.
